branch_resolve: RTL and testbench
=================================

# branch_resolve

EX-stage branch resolution unit; the consumer end of the bimodal predictor's prediction interface. It latches each branch leaving ID with the predicted direction, then evaluates the real outcome against forwarded operands in EX. On a mispredict it issues the front-end redirect, and it queues a direction-update record back toward the predictor table. It also keeps resolved-branch and mispredict counters for the debug/perf readout.

## Interface
- FIFO_DEPTH, 4, update queue entries; power of two, at least 2
- IDX_W, 12, predictor index width; index = pc[IDX_W+1:2]
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- id_branchB  in  1  instruction leaving ID is a branch
- id_brType  in  3  condition code: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 unconditional, 7 reserved
- id_predTaken  in  1  direction used by fetch for this branch
- id_pc  in  32  branch PC
- id_branchDst  in  32  taken target
- ex_stall  in  1  EX holds its instruction this cycle
- ex_flush  in  1  exception squash of the EX slot
- ex_rsData, ex_rtData  in  32 each  forwarded operands of the instruction in EX
- redirect  out  1  mispredict; fetch must load redirectPc; ID must flush
- redirectPc  out  32  corrected PC
- stall_req  out  1  resolving branch blocked by a full update queue
- upd_valid  out  1  update record available
- upd_ready  in  1  predictor accepts the record this cycle
- upd_index  out  IDX_W  predictor entry to update
- upd_taken  out  1  actual direction
- br_count  out  32  resolved branches, wraps
- mp_count  out  32  mispredicts, wraps

## Operation
- EX slot register: {valid, brType, predTaken, pc, dst}.
  - Loads the ID fields when ex_stall=0 and stall_req=0.
  - valid = id_branchB & ~redirect & ~ex_flush. The instruction behind a mispredicting branch is loaded as a bubble.
  - ex_flush clears valid regardless of stall.
- Outcome, signed 32-bit compare:
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BLEZ: rs<=0.
  - BGTZ: rs>0.
  - BLTZ: rs<0.
  - BGEZ: rs>=0.
  - type 6: taken.
  - type 7: not taken, and no queue entry is written.
- Resolve condition: slot valid & ~ex_stall & ~ex_flush & ~stall_req.
- On resolve:
  - mispredict = predTaken ^ taken.
  - redirect = mispredict.
  - redirectPc = taken ? dst : pc+4, with 32-bit wrap.
  - br_count += 1; mp_count += mispredict.
  - Enqueue {pc[IDX_W+1:2], taken} unless type 7.
- stall_req = slot valid & queue full & ~(upd_valid & upd_ready) & type≠7.
  - Simultaneous pop frees a slot; a full queue with a same-cycle pop does not stall.
- Update queue:
  - Circular FIFO with head and tail pointers plus a count.
  - upd_* reflects the head entry. Pop on upd_valid & upd_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Wrap-around at FIFO_DEPTH.
- redirect, redirectPc and stall_req are 0 whenever no resolve or stall applies.
- Reset:
  - Slot invalid; queue empty.
  - upd_valid=0, redirect=0, stall_req=0, redirectPc=0, upd_index=0, upd_taken=0.
  - br_count=0, mp_count=0.

## Timing
- Branch in ID at cycle N → in the slot at N+1. redirect and redirectPc are combinational during N+1.
- The fetch PC mux consumes the redirect at the edge ending N+1.
- Enqueue at the edge ending N+1; upd_valid is high no earlier than N+2, so there is no queue bypass.
- Counters update at the edge ending N+1 and are visible at N+2.
- The predictor applies each update only on the upd_valid & upd_ready edge.
- Multi-cycle ex_stall: outcome is evaluated only in the final, unstalled cycle, so redirect pulses exactly once per branch.
- stall_req is combinational; EX must treat it as ex_stall. A branch held by stall_req resolves in the first cycle the queue has room.
- rst takes priority over all inputs and discards pending queue entries.

## Test plan
- BEQ, rs=rt=5, predTaken=0, pc=0x100, dst=0x200 → redirect=1 and redirectPc=0x200 in the EX cycle; one record {0x40, 1}; mp_count=1, br_count=1.
- BGTZ, rs=0xFFFFFFFF, predTaken=0 → not taken, redirect=0; record {idx, 0}; mp_count unchanged.
- Back-to-back branches: the first mispredicts, the second is in ID → second loads as a bubble; br_count increments by 1 only.
- upd_ready=0 and 5 resolved branches with FIFO_DEPTH=4:
  - 5th branch asserts stall_req.
  - Raise upd_ready for one cycle → pop and push occur together and stall_req drops that cycle.
  - Records drain in order.
- ex_stall for 3 cycles on a mispredicted branch → redirect is high for exactly one cycle, after the stall ends.
- rst asserted with 2 queued records and a valid slot → next cycle upd_valid=0, redirect=0, both counters 0.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution with mispredict redirect, predictor update queue and perf counters
module branch_resolve #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_branchB,
  input  logic [2:0]       id_brType,
  input  logic             id_predTaken,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_branchDst,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic [31:0]      ex_rsData,
  input  logic [31:0]      ex_rtData,
  output logic             redirect,
  output logic [31:0]      redirectPc,
  output logic             stall_req,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_taken,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic v_q, v_d, pt_q;
  logic [2:0] ty_q;
  logic [31:0] pc_q, dst_q, br_q, mp_q;
  logic [IDX_W:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] hd_q, tl_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic eq, neg, zero, taken, resolve, load, push, pop, full;
  assign upd_valid = cnt_q != '0;
  assign upd_index = upd_valid ? mem_q[hd_q][IDX_W:1] : '0;
  assign upd_taken = upd_valid & mem_q[hd_q][0];
  assign br_count = br_q;
  assign mp_count = mp_q;
  always_comb begin
    eq = ex_rsData == ex_rtData;
    neg = ex_rsData[31];
    zero = ex_rsData == '0;
    taken = ty_q == 3'd0 ? eq :
            ty_q == 3'd1 ? ~eq :
            ty_q == 3'd2 ? neg | zero :
            ty_q == 3'd3 ? ~neg & ~zero :
            ty_q == 3'd4 ? neg :
            ty_q == 3'd5 ? ~neg :
            ty_q == 3'd6;
    pop = upd_valid & upd_ready;
    full = cnt_q == CW'(FIFO_DEPTH);
    // a same-cycle pop makes room, so a full queue only blocks when nothing drains
    stall_req = v_q & full & ~pop & (ty_q != 3'd7);
    resolve = v_q & ~ex_stall & ~ex_flush & ~stall_req;
    redirect = resolve & (pt_q ^ taken);
    redirectPc = resolve ? (taken ? dst_q : pc_q + 32'd4) : '0;
    push = resolve & (ty_q != 3'd7);
    load = ~ex_stall & ~stall_req;
    // the instruction behind a mispredicting branch enters as a bubble
    v_d = ex_flush ? 1'b0 : load ? id_branchB & ~redirect : v_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      hd_q <= '0;
      tl_q <= '0;
      cnt_q <= '0;
      br_q <= '0;
      mp_q <= '0;
    end else begin
      v_q <= v_d;
      if (load) begin
        ty_q <= id_brType;
        pt_q <= id_predTaken;
        pc_q <= id_pc;
        dst_q <= id_branchDst;
      end
      if (push) tl_q <= tl_q + AW'(1);
      if (pop) hd_q <= hd_q + AW'(1);
      cnt_q <= cnt_d;
      br_q <= br_q + 32'(resolve);
      mp_q <= mp_q + 32'(redirect);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tl_q] <= {pc_q[IDX_W+1:2], taken};
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench for branch_resolve with directed and random stimulus
module tb_branch_resolve;
  localparam int D = 4;
  localparam int IW = 12;
  logic clk = 0, rst = 1;
  logic id_branchB = 0, id_predTaken = 0, ex_stall = 0, ex_flush = 0, upd_ready = 0;
  logic [2:0] id_brType = 0;
  logic [31:0] id_pc = 0, id_branchDst = 0, ex_rsData = 0, ex_rtData = 0;
  logic redirect, stall_req, upd_valid, upd_taken;
  logic [31:0] redirectPc, br_count, mp_count;
  logic [IW-1:0] upd_index;
  int total = 0, bad = 0;
  typedef struct {logic [IW-1:0] idx; logic tk;} rec_t;
  rec_t exp_q[$];
  logic sv = 0, spt = 0;
  logic [2:0] sty = 0;
  logic [31:0] spc = 0, sdst = 0, mbr = 0, mmp = 0;

  branch_resolve #(.FIFO_DEPTH(D), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .id_branchB(id_branchB), .id_brType(id_brType),
    .id_predTaken(id_predTaken), .id_pc(id_pc), .id_branchDst(id_branchDst),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_rsData(ex_rsData), .ex_rtData(ex_rtData),
    .redirect(redirect), .redirectPc(redirectPc), .stall_req(stall_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_taken(upd_taken), .br_count(br_count), .mp_count(mp_count));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic outcome(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) <= 0;
      3'd3: return $signed(a) > 0;
      3'd4: return $signed(a) < 0;
      3'd5: return $signed(a) >= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one clock cycle: drive at negedge, check combinational outputs at +1, advance the model at +3
  task automatic step(input logic r, input logic b, input logic [2:0] t, input logic p,
                      input logic [31:0] pc, input logic [31:0] dst, input logic [31:0] rs,
                      input logic [31:0] rt, input logic st, input logic fl, input logic rdy);
    logic tk, stx, res, mis;
    logic [31:0] epc;
    @(negedge clk);
    rst = r; id_branchB = b; id_brType = t; id_predTaken = p; id_pc = pc; id_branchDst = dst;
    ex_rsData = rs; ex_rtData = rt; ex_stall = st; ex_flush = fl; upd_ready = rdy;
    #1;
    tk = outcome(sty, rs, rt);
    stx = sv && exp_q.size() == D && !(exp_q.size() != 0 && rdy) && sty != 3'd7;
    res = sv && !st && !fl && !stx;
    mis = res && (spt ^ tk);
    epc = res ? (tk ? sdst : spc + 32'd4) : 32'd0;
    if (!r) begin
      chk("redirect", redirect, mis);
      chk("redirectPc", redirectPc, epc);
      chk("stall_req", stall_req, stx);
      chk("br_count", br_count, mbr);
      chk("mp_count", mp_count, mmp);
    end
    #2;
    if (r) begin
      exp_q.delete();
      sv = 0; mbr = 0; mmp = 0;
    end else begin
      if (res) begin
        mbr++;
        mmp += 32'(mis);
        if (sty != 3'd7) exp_q.push_back('{spc[IW+1:2], tk});
      end
      if (fl) sv = 0;
      else if (!st && !stx) begin
        sv = b && !mis; sty = t; spt = p; spc = pc; sdst = dst;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("upd_valid", upd_valid, exp_q.size() != 0);
        if (upd_valid && upd_ready && exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("upd_index", 32'(upd_index), 32'(r.idx));
          chk("upd_taken", upd_taken, r.tk);
        end
      end
    end
  end

  initial begin
    logic [31:0] u, rs;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_br", br_count, 0);
    // BEQ taken, predicted not taken
    step(0, 1, 0, 0, 32'h100, 32'h200, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 1);
    chk("tp1_redirect", redirect, 1);
    chk("tp1_pc", redirectPc, 32'h200);
    idle(0);
    chk("tp1_idx", 32'(upd_index), 32'h40);
    chk("tp1_tk", upd_taken, 1);
    chk("tp1_mp", mp_count, 1);
    chk("tp1_br", br_count, 1);
    idle(1);
    // BGTZ on a negative operand
    step(0, 1, 3, 0, 32'h300, 32'h400, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    chk("tp2_redirect", redirect, 0);
    idle(1);
    chk("tp2_mp", mp_count, 1);
    // mispredict followed by a branch in ID: second becomes a bubble
    step(0, 1, 6, 0, 32'h500, 32'h600, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 32'h504, 32'h700, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    chk("tp3_br", br_count, 3);
    // full queue stalls the fifth branch until a pop frees room
    for (int i = 0; i < 5; i++) step(0, 1, 6, 1, 32'h1000 + 32'(i * 4), 32'h2000, 0, 0, 0, 0, 0);
    idle(0);
    chk("tp4_stall", stall_req, 1);
    idle(0);
    chk("tp4_stall2", stall_req, 1);
    idle(1);
    chk("tp4_nostall", stall_req, 0);
    repeat (6) idle(1);
    chk("tp4_br", br_count, 8);
    // mispredicted BNE held by a 3-cycle stall
    step(0, 1, 1, 1, 32'h900, 32'hA00, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 7, 7, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 1);
    chk("tp5_redirect", redirect, 1);
    chk("tp5_pc", redirectPc, 32'h904);
    idle(1);
    chk("tp5_once", redirect, 0);
    // reset with queued records and a live slot
    step(0, 1, 6, 1, 32'h40, 32'h80, 0, 0, 0, 0, 0);
    step(0, 1, 6, 1, 32'h44, 32'h80, 0, 0, 0, 0, 0);
    step(0, 1, 6, 0, 32'h48, 32'h80, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("tp6_valid", upd_valid, 0);
    chk("tp6_redirect", redirect, 0);
    chk("tp6_br", br_count, 0);
    chk("tp6_mp", mp_count, 0);
    // random traffic with alternating drain pressure
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      u = $urandom;
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : {u[31:2], 2'b00};
      rs = pick();
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), pc, $urandom, rs, $urandom_range(0, 1) ? rs : pick(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
           ((i / 100) % 2) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
    end
    repeat (8) idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
